led_rotator_ctrl: RTL and testbench

Control front end for the LED rotator stage. Debounces and edge-detects two push buttons, toggling the rotator's `en` and `dir` levels on each press. Generates single-cycle rate ticks that replace divided clocks, and routes the fast and slow rates to the single-LED and triple-LED patterns according to `dir`. All logic runs in the single `clk` domain; its outputs feed the rotator stage directly.

---
 rtl/led_rotator_ctrl.sv | 125 ++++++++++++
 tb/tb_led_rotator_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_rotator_ctrl.sv
// Control front end for the LED rotator: debounced push-button toggles for en/dir
// and a single free-running rate counter producing the routed step strobes.

module led_rotator_deb #(
   parameter int SAMPLE_N = 16,
   parameter int DEB_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   localparam logic [SAMPLE_N-1:0] SAMPLE_ONE = {{(SAMPLE_N-1){1'b0}}, 1'b1};

   logic [1:0]          r_sync;
   logic [SAMPLE_N-1:0] r_sample_cnt;
   logic [DEB_LEN-1:0]  r_hist;
   logic                r_deb;
   logic                r_deb_d;
   logic                w_strobe;

   assign w_strobe = &r_sample_cnt;

   // The level only moves on a history that is unanimous; mixed histories hold it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync       <= 2'b00;
         r_sample_cnt <= '0;
         r_hist       <= '0;
         r_deb        <= 1'b0;
         r_deb_d      <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], i_btn};
         r_sample_cnt <= r_sample_cnt + SAMPLE_ONE;
         if (w_strobe) begin
            r_hist <= {r_hist[DEB_LEN-2:0], r_sync[1]};
         end
         if (&r_hist) begin
            r_deb <= 1'b1;
         end else if (~|r_hist) begin
            r_deb <= 1'b0;
         end
         r_deb_d <= r_deb;
      end
   end

   assign o_press = r_deb & ~r_deb_d;

endmodule

module led_rotator_ctrl #(
   parameter int SAMPLE_N = 16,
   parameter int DEB_LEN  = 4,
   parameter int FAST_N   = 23,
   parameter int SLOW_N   = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_en,
   input  logic btn_dir,
   output logic en,
   output logic dir,
   output logic one_tick,
   output logic three_tick
);

   localparam logic [SLOW_N-1:0] RATE_ONE = {{(SLOW_N-1){1'b0}}, 1'b1};

   logic              w_press_en;
   logic              w_press_dir;
   logic              w_fast_nxt;
   logic              w_slow_nxt;
   logic              r_en;
   logic              r_dir;
   logic              r_one_tick;
   logic              r_three_tick;
   logic [SLOW_N-1:0] r_rate_cnt;

   led_rotator_deb #(
      .SAMPLE_N (SAMPLE_N),
      .DEB_LEN  (DEB_LEN)
   ) u_deb_en (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_en),
      .o_press (w_press_en)
   );

   led_rotator_deb #(
      .SAMPLE_N (SAMPLE_N),
      .DEB_LEN  (DEB_LEN)
   ) u_deb_dir (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_dir),
      .o_press (w_press_dir)
   );

   // A slow wrap always implies a fast wrap, so both ticks share one counter.
   assign w_fast_nxt = &r_rate_cnt[FAST_N-1:0];
   assign w_slow_nxt = &r_rate_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_en         <= 1'b1;
         r_dir        <= 1'b1;
         r_rate_cnt   <= '0;
         r_one_tick   <= 1'b0;
         r_three_tick <= 1'b0;
      end else begin
         r_en         <= r_en ^ w_press_en;
         r_dir        <= r_dir ^ w_press_dir;
         r_rate_cnt   <= r_rate_cnt + RATE_ONE;
         r_one_tick   <= r_dir ? w_slow_nxt : w_fast_nxt;
         r_three_tick <= r_dir ? w_fast_nxt : w_slow_nxt;
      end
   end

   assign en         = r_en;
   assign dir        = r_dir;
   assign one_tick   = r_one_tick;
   assign three_tick = r_three_tick;

endmodule

// File: tb/tb_led_rotator_ctrl.sv
// Bench for led_rotator_ctrl: directed scenarios plus random button traffic,
// all checked cycle by cycle against a sample-history reference model.

module tb_led_rotator_ctrl;

   localparam int SAMPLE_N = 2;
   localparam int DEB_LEN  = 4;
   localparam int FAST_N   = 3;
   localparam int SLOW_N   = 5;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic btn_en  = 1'b0;
   logic btn_dir = 1'b0;
   logic en, dir, one_tick, three_tick;

   int checks   = 0;
   int failures = 0;

   led_rotator_ctrl #(
      .SAMPLE_N (SAMPLE_N),
      .DEB_LEN  (DEB_LEN),
      .FAST_N   (FAST_N),
      .SLOW_N   (SLOW_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_en     (btn_en),
      .btn_dir    (btn_dir),
      .en         (en),
      .dir        (dir),
      .one_tick   (one_tick),
      .three_tick (three_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at each rising edge, plus edges since reset.
   logic cap_rst  = 1'b0;
   logic cap_ben  = 1'b0;
   logic cap_bdir = 1'b0;
   int   cyc = 0;
   int   ek  = 0;

   always @(posedge clk) begin
      cap_rst  <= rst;
      cap_ben  <= btn_en;
      cap_bdir <= btn_dir;
      cyc      <= cyc + 1;
      if (rst) ek <= 0;
      else     ek <= ek + 1;
   end

   // Reference model: a button level changes once the last DEB_LEN samples
   // (one every 2^SAMPLE_N edges, taken two edges late) all agree.
   int mk;
   bit m_valid = 1'b0;
   bit m_en, m_dir, m_one, m_three;
   bit d1[2], d2[2], deb1[2], deb2[2], run_val[2];
   int run_len[2];

   initial forever begin
      bit cur[2];
      bit tog[2];
      bit dir_old;
      bit deb_now;
      bit smp;
      @(negedge clk);
      if (cap_rst) begin
         mk = 0; m_valid = 1'b1;
         m_en = 1'b1; m_dir = 1'b1; m_one = 1'b0; m_three = 1'b0;
         for (int b = 0; b < 2; b++) begin
            d1[b] = 0; d2[b] = 0; deb1[b] = 0; deb2[b] = 0;
            run_val[b] = 0; run_len[b] = DEB_LEN;
         end
      end else if (m_valid) begin
         mk++;
         cur[0] = cap_ben;
         cur[1] = cap_bdir;
         for (int b = 0; b < 2; b++) begin
            deb_now = (run_len[b] >= DEB_LEN) ? run_val[b] : deb1[b];
            tog[b]  = deb1[b] && !deb2[b];
            deb2[b] = deb1[b];
            deb1[b] = deb_now;
            if (mk % (1 << SAMPLE_N) == 0) begin
               smp = d2[b];
               if (smp == run_val[b]) begin
                  if (run_len[b] < DEB_LEN) run_len[b]++;
               end else begin
                  run_val[b] = smp;
                  run_len[b] = 1;
               end
            end
            d2[b] = d1[b];
            d1[b] = cur[b];
         end
         dir_old = m_dir;
         m_en  ^= tog[0];
         m_dir ^= tog[1];
         m_one   = dir_old ? (mk % (1 << SLOW_N) == 0) : (mk % (1 << FAST_N) == 0);
         m_three = dir_old ? (mk % (1 << FAST_N) == 0) : (mk % (1 << SLOW_N) == 0);
      end
      if (m_valid) begin
         check_eq("model_en", en, m_en);
         check_eq("model_dir", dir, m_dir);
         check_eq("model_one_tick", one_tick, m_one);
         check_eq("model_three_tick", three_tick, m_three);
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t0, lat, tog, ones, threes, both, first_one, first_three, te, td;
      logic prev;

      // Reset release, idle buttons
      repeat (3) @(negedge clk);
      check_eq("rst_en", en, 1);
      check_eq("rst_dir", dir, 1);
      check_eq("rst_one_tick", one_tick, 0);
      check_eq("rst_three_tick", three_tick, 0);
      rst = 1'b0;
      ones = 0; threes = 0; both = 0; first_one = -1; first_three = -1;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (one_tick) begin ones++; if (first_one < 0) first_one = i; end
         if (three_tick) begin threes++; if (first_three < 0) first_three = i; end
         if (one_tick && three_tick) both++;
      end
      check_eq("idle_first_three", first_three, 8);
      check_eq("idle_first_one", first_one, 32);
      check_eq("idle_three_count", threes, 8);
      check_eq("idle_one_count", ones, 2);
      check_eq("idle_coincide", both, 2);

      // btn_dir held for 40 cycles
      btn_dir = 1'b1; t0 = cyc; tog = 0; lat = -1; prev = dir;
      repeat (40) begin
         @(negedge clk);
         if (dir !== prev) begin tog++; if (lat < 0) lat = cyc - t0; end
         prev = dir;
      end
      btn_dir = 1'b0;
      check_eq("dirhold_toggles", tog, 1);
      check_eq("dirhold_latency_ok", int'(lat >= 16 && lat <= 24), 1);
      check_eq("dirhold_dir", dir, 0);
      repeat (40) @(negedge clk);
      ones = 0; threes = 0;
      repeat (64) begin
         @(negedge clk);
         if (one_tick) ones++;
         if (three_tick) threes++;
      end
      check_eq("dir0_one_count", ones, 8);
      check_eq("dir0_three_count", threes, 2);
      check_eq("dir0_release_no_toggle", dir, 0);

      // btn_en chattering every cycle, phased so every sample sees it low
      tog = 0; prev = en;
      repeat (30) begin
         @(negedge clk);
         btn_en = logic'((ek + 1) & 1);
         if (en !== prev) tog++;
         prev = en;
      end
      btn_en = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (en !== prev) tog++;
         prev = en;
      end
      check_eq("bounce_toggles", tog, 0);
      check_eq("bounce_en", en, 1);

      // Both buttons together, twice
      do_reset(2);
      for (int p = 0; p < 2; p++) begin
         btn_en = 1'b1; btn_dir = 1'b1; te = -1; td = -1;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (te < 0 && en !== logic'(p)) te = i;
            if (td < 0 && dir !== logic'(p)) td = i;
         end
         btn_en = 1'b0; btn_dir = 1'b0;
         repeat (30) @(negedge clk);
         check_eq("both_same_cycle", te, td);
         check_eq("both_seen", int'(te >= 0), 1);
         check_eq("both_en", en, p);
         check_eq("both_dir", dir, p);
      end

      // btn_dir held across a reset pulse
      do_reset(2);
      repeat (30) @(negedge clk);
      btn_dir = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("midrst_dir_restored", dir, 1);
      rst = 1'b0; t0 = cyc; tog = 0; lat = -1; prev = dir;
      repeat (40) begin
         @(negedge clk);
         if (dir !== prev) begin tog++; if (lat < 0) lat = cyc - t0; end
         prev = dir;
      end
      btn_dir = 1'b0;
      check_eq("midrst_toggles", tog, 1);
      check_eq("midrst_latency_ok", int'(lat >= 0 && lat <= 24), 1);

      // Random traffic including bounces and occasional resets
      for (int s = 0; s < 120; s++) begin
         int len;
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
         else len = $urandom_range(4, 40);
         btn_en  = logic'($urandom_range(0, 1));
         btn_dir = logic'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
         end
         repeat (len) @(negedge clk);
      end
      btn_en = 1'b0; btn_dir = 1'b0;
      repeat (40) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
